// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter from NUM_PORTS requesters onto one
// byte-serial 8-bit RAM/IO port. Supports 1/2/4-byte loads with sign/zero
// extension, 1/2/4-byte stores, IO write back-pressure and read flush.
module mem_arbiter_rr #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned IO_BASE   = 32'h30000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          flush,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS-1:0]          req_we,
    input  logic [NUM_PORTS-1:0]          req_sign,
    input  logic [2*NUM_PORTS-1:0]        req_size,
    input  logic [ADDR_W*NUM_PORTS-1:0]   req_addr,
    input  logic [32*NUM_PORTS-1:0]       req_wdata,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic [NUM_PORTS-1:0]          resp_valid,
    output logic [31:0]                   resp_rdata,
    input  logic [7:0]                    mem_din,
    output logic [7:0]                    mem_dout,
    output logic [ADDR_W-1:0]             mem_a,
    output logic                          mem_wr,
    input  logic                          io_buffer_full
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    port_q, port_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [2:0]          len_q, len_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                sign_q, sign_d;
    logic                io_q, io_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         data_q, data_d;

    logic [NUM_PORTS-1:0] req_ready_d;
    logic [NUM_PORTS-1:0] resp_valid_d;
    logic [31:0]          resp_rdata_d;
    logic [7:0]           mem_dout_d;
    logic [ADDR_W-1:0]    mem_a_d;
    logic                 mem_wr_d;

    logic [NUM_PORTS-1:0] elig;
    logic                 gnt_found;
    logic [PTR_W-1:0]     gnt_idx;
    logic                 sel_we;
    logic                 sel_sign;
    logic [1:0]           sel_size;
    logic [ADDR_W-1:0]    sel_addr;
    logic [31:0]          sel_wdata;

    logic [31:0]          asm_data;
    logic [1:0]           cap_idx;
    logic [2:0]           rd_nxt;
    logic [2:0]           wr_nxt;
    logic                 wr_done;

    // Cyclic port index: (base + off) mod NUM_PORTS, with base, off < NUM_PORTS
    function automatic logic [PTR_W-1:0] rot(input logic [PTR_W-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_PORTS) begin
            sum = sum - NUM_PORTS;
        end
        return PTR_W'(sum);
    endfunction

    // Access length in bytes; size 3 behaves as a word
    function automatic logic [2:0] len_of(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            2'd0:    n = 3'd1;
            2'd1:    n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Sign or zero extension of the assembled load bytes
    function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] len, input logic sgn);
        logic [31:0] r;
        case (len)
            3'd1:    r = {{24{sgn & d[7]}}, d[7:0]};
            3'd2:    r = {{16{sgn & d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Eligible ports: valid, and not an IO store while the IO buffer is full
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            elig[i] = req_valid[i] &&
                      !(req_we[i] && io_buffer_full &&
                        (req_addr[i*ADDR_W +: ADDR_W] >= IO_BASE_A));
        end
    end

    // Round-robin pick starting at the pointer, plus the winner's fields
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (!gnt_found && elig[rot(ptr_q, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = rot(ptr_q, k);
            end
        end
        sel_we    = req_we[gnt_idx];
        sel_sign  = req_sign[gnt_idx];
        sel_size  = req_size[32'(gnt_idx)*2 +: 2];
        sel_addr  = req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[32'(gnt_idx)*32 +: 32];
    end

    // Next-state and registered-output values
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        port_d       = port_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        addr_d       = addr_q;
        sign_d       = sign_q;
        io_d         = io_q;
        wdata_d      = wdata_q;
        data_d       = data_q;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_rdata_d = resp_rdata;
        mem_dout_d   = mem_dout;
        mem_a_d      = mem_a;
        mem_wr_d     = mem_wr;
        asm_data     = data_q;
        cap_idx      = 2'(cnt_q - 3'd1);
        rd_nxt       = 3'd0;
        wr_nxt       = cnt_q;
        wr_done      = 1'b0;

        case (state_q)
            IDLE: begin
                mem_wr_d = 1'b0;
                if (gnt_found) begin
                    ptr_d                = rot(gnt_idx, 1);
                    port_d               = gnt_idx;
                    req_ready_d[gnt_idx] = 1'b1;
                    cnt_d                = 3'd0;
                    len_d                = len_of(sel_size);
                    addr_d               = sel_addr;
                    sign_d               = sel_sign;
                    io_d                 = (sel_addr >= IO_BASE_A);
                    wdata_d              = sel_wdata;
                    data_d               = '0;
                    mem_a_d              = sel_addr;
                    if (sel_we) begin
                        state_d    = WRITE;
                        mem_dout_d = sel_wdata[7:0];
                        mem_wr_d   = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end
            end

            READ: begin
                mem_wr_d = 1'b0;
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    // First edge in READ only covers RAM latency; later edges capture
                    if (cnt_q != 3'd0) begin
                        asm_data[{cap_idx, 3'b000} +: 8] = mem_din;
                    end
                    data_d = asm_data;
                    if (cnt_q == len_q) begin
                        state_d              = IDLE;
                        cnt_d                = 3'd0;
                        resp_valid_d[port_q] = 1'b1;
                        resp_rdata_d         = extend(asm_data, len_q, sign_q);
                    end else begin
                        cnt_d   = cnt_q + 3'd1;
                        rd_nxt  = ((cnt_q + 3'd1) < len_q) ? (cnt_q + 3'd1) : (len_q - 3'd1);
                        mem_a_d = addr_q + ADDR_W'(rd_nxt);
                    end
                end
            end

            WRITE: begin
                // A byte counts as written only in a cycle with mem_wr high
                if (mem_wr) begin
                    if (cnt_q == (len_q - 3'd1)) begin
                        wr_done = 1'b1;
                    end else begin
                        wr_nxt = cnt_q + 3'd1;
                    end
                end
                if (wr_done) begin
                    state_d              = IDLE;
                    cnt_d                = 3'd0;
                    mem_wr_d             = 1'b0;
                    resp_valid_d[port_q] = 1'b1;
                end else begin
                    cnt_d      = wr_nxt;
                    mem_a_d    = addr_q + ADDR_W'(wr_nxt);
                    mem_dout_d = wdata_q[{wr_nxt[1:0], 3'b000} +: 8];
                    mem_wr_d   = !(io_q && io_buffer_full);
                end
            end

            default: begin
                state_d  = IDLE;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // State and output registers; rdy low freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            port_q     <= '0;
            cnt_q      <= 3'd0;
            len_q      <= 3'd1;
            addr_q     <= '0;
            sign_q     <= 1'b0;
            io_q       <= 1'b0;
            wdata_q    <= '0;
            data_q     <= '0;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
            mem_dout   <= '0;
            mem_a      <= '0;
            mem_wr     <= 1'b0;
        end else if (rdy) begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            port_q     <= port_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            sign_q     <= sign_d;
            io_q       <= io_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            mem_dout   <= mem_dout_d;
            mem_a      <= mem_a_d;
            mem_wr     <= mem_wr_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr with a byte RAM model (one-cycle read latency).
module tb_mem_arbiter_rr;

    localparam int unsigned NP = 2;
    localparam int unsigned AW = 32;

    logic               clk;
    logic               rst;
    logic               rdy;
    logic               flush;
    logic [NP-1:0]      req_valid;
    logic [NP-1:0]      req_we;
    logic [NP-1:0]      req_sign;
    logic [2*NP-1:0]    req_size;
    logic [AW*NP-1:0]   req_addr;
    logic [32*NP-1:0]   req_wdata;
    logic [NP-1:0]      req_ready;
    logic [NP-1:0]      resp_valid;
    logic [31:0]        resp_rdata;
    logic [7:0]         mem_din;
    logic [7:0]         mem_dout;
    logic [AW-1:0]      mem_a;
    logic               mem_wr;
    logic               io_buffer_full;

    logic [7:0]         ram [0:262143];
    logic               pre_we;
    logic [17:0]        pre_addr;
    logic [7:0]         pre_data;

    int                 errors = 0;
    int                 checks = 0;
    int unsigned        cyc = 0;
    int                 rv_cnt [NP];
    int unsigned        wr_cnt = 0;
    int                 gnt_q [$];
    int unsigned        gnt_t [$];

    mem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_W(AW), .IO_BASE(32'h30000)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_sign       (req_sign),
        .req_size       (req_size),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model, enabled by rdy like the rest of the memory system
    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (rdy) begin
            if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
            mem_din <= ram[mem_a[17:0]];
        end
    end

    // Event log: grants, responses and write cycles
    initial for (int p = 0; p < NP; p++) rv_cnt[p] = 0;
    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (req_ready[p]) begin
                gnt_q.push_back(p);
                gnt_t.push_back(cyc);
            end
            if (resp_valid[p]) rv_cnt[p] = rv_cnt[p] + 1;
        end
        if (mem_wr) wr_cnt = wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [17:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic set_req(input int p, input logic we, input logic sg, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        req_we[p]            = we;
        req_sign[p]          = sg;
        req_size[p*2 +: 2]   = sz;
        req_addr[p*AW +: AW] = a;
        req_wdata[p*32 +: 32] = wd;
        req_valid[p]         = 1'b1;
    endtask

    task automatic wait_rr(input int p, output int unsigned c);
        bit seen;
        seen = 1'b0;
        c    = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (req_ready[p]) begin
                seen = 1'b1;
                c    = cyc;
            end
        end
        req_valid[p] = 1'b0;
        check($sformatf("grant_seen_p%0d", p), 32'(seen), 32'd1);
    endtask

    task automatic wait_resp(input int p, output int unsigned c, output logic [31:0] d);
        bit seen;
        seen = 1'b0;
        c    = 0;
        d    = '0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (resp_valid[p]) begin
                seen = 1'b1;
                c    = cyc;
                d    = resp_rdata;
            end
        end
        check($sformatf("resp_seen_p%0d", p), 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c_rr, c_rv, c2, c3, w0;
        int          r0, g0;
        logic [31:0] d;

        rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        req_valid = '0; req_we = '0; req_sign = '0; req_size = '0;
        req_addr = '0; req_wdata = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        repeat (2) @(negedge clk);
        poke(18'h100, 8'h11); poke(18'h101, 8'h22);
        poke(18'h102, 8'h33); poke(18'h103, 8'h44);
        poke(18'h200, 8'h80); poke(18'h201, 8'hFF);

        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wr", 32'(mem_wr), 32'h0);
        check("rst_mem_dout", 32'(mem_dout), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Port 1 word load
        set_req(1, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
        wait_rr(1, c_rr);
        wait_resp(1, c_rv, d);
        check("lw_data", d, 32'h44332211);
        check("lw_latency", c_rv - c_rr, 32'd5);

        // Port 0 signed byte load
        set_req(0, 1'b0, 1'b1, 2'd0, 32'h200, 32'h0);
        wait_rr(0, c_rr);
        wait_resp(0, c_rv, d);
        check("lb_data", d, 32'hFFFFFF80);
        check("lb_latency", c_rv - c_rr, 32'd2);

        // IO store gated while buffer full; port 0 load goes first
        io_buffer_full = 1'b1;
        set_req(1, 1'b1, 1'b0, 2'd0, 32'h30000, 32'h0000005A);
        set_req(0, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
        wait_rr(0, c_rr);
        @(negedge clk);
        @(negedge clk);
        io_buffer_full = 1'b0;
        wait_resp(0, c_rv, d);
        check("io_load_data", d, 32'h44332211);
        wait_rr(1, c2);
        check("io_store_after_load", c2 - c_rv, 32'd1);
        wait_resp(1, c3, d);
        check("sb_io_latency", c3 - c2, 32'd1);
        check("sb_rdata_kept", d, 32'h44332211);
        #1;
        check("sb_io_ram", 32'(ram[18'h30000]), 32'h5A);

        // IO word store stalled two cycles by buffer full
        w0 = wr_cnt;
        set_req(0, 1'b1, 1'b0, 2'd2, 32'h30010, 32'h11223344);
        wait_rr(0, c_rr);
        io_buffer_full = 1'b1;
        @(negedge clk);
        @(negedge clk);
        io_buffer_full = 1'b0;
        wait_resp(0, c_rv, d);
        check("sw_io_stall_latency", c_rv - c_rr, 32'd6);
        #1;
        check("sw_io_stall_wr_cycles", wr_cnt - w0, 32'd4);
        check("sw_io_stall_ram", {ram[18'h30013], ram[18'h30012], ram[18'h30011], ram[18'h30010]}, 32'h11223344);

        // Plain word store then read back
        w0 = wr_cnt;
        set_req(0, 1'b1, 1'b0, 2'd2, 32'h40, 32'hDEADBEEF);
        wait_rr(0, c_rr);
        wait_resp(0, c_rv, d);
        check("sw_latency", c_rv - c_rr, 32'd4);
        check("sw_rdata_kept", d, 32'h44332211);
        #1;
        check("sw_wr_cycles", wr_cnt - w0, 32'd4);
        check("sw_ram", {ram[18'h43], ram[18'h42], ram[18'h41], ram[18'h40]}, 32'hDEADBEEF);
        set_req(1, 1'b0, 1'b0, 2'd2, 32'h40, 32'h0);
        wait_rr(1, c_rr);
        wait_resp(1, c_rv, d);
        check("lw_readback", d, 32'hDEADBEEF);

        // Halfword and byte extension variants
        set_req(1, 1'b0, 1'b0, 2'd1, 32'h200, 32'h0);
        wait_rr(1, c_rr);
        wait_resp(1, c_rv, d);
        check("lhu_data", d, 32'h0000FF80);
        check("lhu_latency", c_rv - c_rr, 32'd3);
        set_req(0, 1'b0, 1'b1, 2'd1, 32'h200, 32'h0);
        wait_rr(0, c_rr);
        wait_resp(0, c_rv, d);
        check("lh_data", d, 32'hFFFFFF80);
        set_req(1, 1'b0, 1'b0, 2'd0, 32'h200, 32'h0);
        wait_rr(1, c_rr);
        wait_resp(1, c_rv, d);
        check("lbu_data", d, 32'h00000080);

        // Flush after two captures; port 1 granted on the next idle cycle
        #1;
        r0 = rv_cnt[0];
        set_req(0, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
        wait_rr(0, c_rr);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        set_req(1, 1'b0, 1'b0, 2'd0, 32'h200, 32'h0);
        @(negedge clk);
        flush = 1'b0;
        wait_rr(1, c2);
        check("flush_regrant", c2 - c_rr, 32'd5);
        wait_resp(1, c3, d);
        check("flush_next_data", d, 32'h00000080);
        #1;
        check("flush_no_resp", 32'(rv_cnt[0] - r0), 32'd0);

        // rdy low for three edges stretches a word load
        set_req(0, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
        wait_rr(0, c_rr);
        @(negedge clk);
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        rdy = 1'b1;
        wait_resp(0, c_rv, d);
        check("rdy_freeze_latency", c_rv - c_rr, 32'd8);
        check("rdy_freeze_data", d, 32'h44332211);

        // Both ports requesting continuously from reset alternate 0,1,0,1
        rst = 1'b1;
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
        set_req(1, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
        #1;
        g0 = gnt_q.size();
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #1;
            if (gnt_q.size() >= g0 + 4) break;
        end
        req_valid = '0;
        check("alt_grant0", 32'(gnt_q[g0]), 32'd0);
        check("alt_grant1", 32'(gnt_q[g0+1]), 32'd1);
        check("alt_grant2", 32'(gnt_q[g0+2]), 32'd0);
        check("alt_grant3", 32'(gnt_q[g0+3]), 32'd1);
        check("alt_span", gnt_t[g0+3] - gnt_t[g0], 32'd18);
        wait_resp(1, c_rv, d);
        check("alt_last_data", d, 32'h44332211);

        // Reset in the middle of a store abandons it
        #1;
        r0 = rv_cnt[0];
        set_req(0, 1'b1, 1'b0, 2'd2, 32'h50, 32'hCAFEF00D);
        wait_rr(0, c_rr);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_mem_wr", 32'(mem_wr), 32'h0);
        check("midrst_mem_a", mem_a, 32'h0);
        check("midrst_mem_dout", 32'(mem_dout), 32'h0);
        check("midrst_resp_valid", 32'(resp_valid), 32'h0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("midrst_no_resp", 32'(rv_cnt[0] - r0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised byte-serial memory arbiter between NUM_PORTS requesters (instruction cache, LSB, future prefetcher/DMA) and the single 8-bit RAM/IO port. It uses round-robin fair arbitration and supports 1/2/4-byte loads with sign or zero extension and 1/2/4-byte stores. It also provides IO back-pressure via io_buffer_full and a read-flush for branch mispredict recovery.

## Interface
- NUM_PORTS, 2: number of requesters (1..8)
- ADDR_W, 32: address width
- IO_BASE, 32'h30000: start of IO region; an access is IO when addr >= IO_BASE
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state and outputs
- flush  in  1  abort any read in progress
- req_valid  in  NUM_PORTS  request per port; held with fields stable until req_ready
- req_we  in  NUM_PORTS  1 = store, 0 = load
- req_sign  in  NUM_PORTS  load sign-extend (LB/LH) when 1
- req_size  in  2*NUM_PORTS  0 = 1B, 1 = 2B, 2 = 4B, 3 = treated as 4B
- req_addr  in  ADDR_W*NUM_PORTS  byte address; port i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  32*NUM_PORTS  store data, little-endian
- req_ready  out  NUM_PORTS  one-cycle pulse: request accepted, fields latched
- resp_valid  out  NUM_PORTS  one-cycle pulse: access complete
- resp_rdata  out  32  extended load data, valid with resp_valid
- mem_din  in  8  RAM read byte; reflects the mem_a of the previous cycle
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_W  RAM address
- mem_wr  out  1  1 = write, 0 = read
- io_buffer_full  in  1  IO write buffer full

## Operation
- States: IDLE, READ, WRITE. All outputs are registered.
- Reset values: state IDLE; rr pointer 0; mem_a 0; mem_dout 0; mem_wr 0; req_ready 0; resp_valid 0; resp_rdata 0; byte counter 0.
- IDLE arbitration: grant the first valid port at or after the rr pointer, searching cyclically. On grant:
  - pointer becomes (grant+1) mod NUM_PORTS
  - req_ready[grant] pulses
  - addr, size, sign, wdata and port id are latched
- IO store gating: a store to IO while io_buffer_full=1 is not granted. Arbitration skips it and serves other ports; the store is retried next cycle.
- N = 1, 2 or 4 from size.
- READ:
  - byte k (k = 0..N-1) is sampled from mem_din one cycle after mem_a = addr+k is driven
  - mem_a increments each cycle until addr+N-1
  - after the last byte, resp_rdata = assembled bytes, sign- or zero-extended to 32 bits for N<4
  - resp_valid[port] pulses; go to IDLE
- WRITE:
  - cycle k drives mem_a = addr+k, mem_dout = wdata byte k, mem_wr = 1
  - after byte N-1: mem_wr = 0, resp_valid[port] pulses, go to IDLE
  - resp_rdata is unchanged
- IO stall: during WRITE to IO, if io_buffer_full=1, mem_wr = 0 and the byte index holds until the buffer is no longer full.
- flush in READ: return to IDLE next edge with no resp_valid and mem_wr 0. The rr pointer keeps its post-grant value.
- flush in WRITE or IDLE: ignored; stores always complete.
- rst mid-access: abandon immediately; all outputs go to their reset values; no response is issued.
- rdy=0: no state, counter or output changes; the requester keeps its handshake.

## Timing
- Grant: request seen at edge E0 → req_ready, mem_a = addr (and first write byte) visible in the cycle after E0.
- Load of N bytes: resp_valid is visible N+1 cycles after req_ready (the 4-byte load has one cycle of RAM latency plus 4 captures).
- Store of N bytes: mem_wr is high for N cycles starting with req_ready; resp_valid is high in the cycle after the last write cycle, plus stall cycles.
- One IDLE cycle between consecutive accesses. Peak throughput is one 4B load per 6 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle. Ungranted ports keep req_valid and are not lost.
- flush on the same edge as the final capture: flush wins; no resp_valid.
- req_valid dropped before req_ready: the request is silently withdrawn (legal for IC after a branch).

## Test plan
- Port 1: 4B load at 0x100 with RAM bytes 0x11,0x22,0x33,0x44 → resp_rdata 0x44332211, resp_valid[1] 5 cycles after req_ready[1].
- LB at 0x200 = 0x80, sign=1 → 0xFFFFFF80. LHU at 0x200 = {0x80,0xFF} → 0x0000FF80.
- SW 0xDEADBEEF to 0x40 → mem_wr high 4 cycles, bytes EF,BE,AD,DE at 0x40..0x43, then resp_valid.
- Ports 0 and 1 request continuously from reset → grants alternate 0,1,0,1; neither port waits more than one access.
- SB to 0x30000 with io_buffer_full=1 for 3 cycles while port 0 loads → the load completes first; the store issues after full drops.
- 4B load with flush asserted after 2 captures → no resp_valid; a following request is granted on the next IDLE cycle.
